// File: rtl/tx_fifo_pkg.sv
// Shared SSP definitions: default FIFO geometry, derived pointer width and
// the per-cycle FIFO operation decode used by the transmit FIFO. The receive
// FIFO is meant to reuse the same decode.
package tx_fifo_pkg;

  localparam int SSP_WIDTH = 8;
  localparam int SSP_DEPTH = 4;
  localparam int SSP_PTR_W = (SSP_DEPTH > 1) ? $clog2(SSP_DEPTH) : 1;

  // What the FIFO actually does on a given edge, after full/empty qualification.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  // Full and empty are judged on the count at the start of the cycle. A full
  // FIFO drops a push even when a pop frees a slot on the same edge. An empty
  // FIFO ignores a pop even when a push lands on the same edge, so there is
  // never a bypass path to the output.
  function automatic fifo_op_e decode_op(
    input logic push_req,
    input logic pop_req,
    input logic full,
    input logic empty
  );
    logic do_push;
    logic do_pop;
    do_push = push_req & ~full;
    do_pop  = pop_req & ~empty;
    return fifo_op_e'({do_pop, do_push});
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Transmit FIFO for the SSP. The APB side pushes words and the transmit logic
// pops them. Storage is a circular buffer with registered pointers and an
// occupancy count. The interrupt is raised while the FIFO is full.
module tx_fifo
  import tx_fifo_pkg::*;
#(
  parameter int WIDTH = SSP_WIDTH,
  parameter int DEPTH = SSP_DEPTH
) (
  input  logic             pclk,
  input  logic             clear_b,
  input  logic             psel,
  input  logic             pwrite,
  input  logic             t_en,
  input  logic [WIDTH-1:0] pwdata,
  output logic             ssptxintr,
  output logic [WIDTH-1:0] txdata
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic [PTR_W-1:0] wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_next;
  logic [CNT_W-1:0] count_next;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;
  fifo_op_e         op;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign op    = decode_op(psel & pwrite, t_en, full, empty);

  // Next pointers and count for this edge. The pointers wrap explicitly at
  // DEPTH-1, so FIFO order holds across any number of wraps.
  always_comb begin
    do_push     = 1'b0;
    do_pop      = 1'b0;
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    count_next  = count;
    case (op)
      OP_PUSH: begin
        do_push    = 1'b1;
        count_next = count + 1'b1;
      end
      OP_POP: begin
        do_pop     = 1'b1;
        count_next = count - 1'b1;
      end
      OP_BOTH: begin
        do_push = 1'b1;
        do_pop  = 1'b1;
      end
      default: begin
        do_push = 1'b0;
        do_pop  = 1'b0;
      end
    endcase
    if (do_push) begin
      wr_ptr_next = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_next = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
    end
  end

  // Storage array is write-only on push and is not reset. Stale words become
  // unreachable once the pointers and count are cleared.
  always_ff @(posedge pclk) begin
    if (do_push) begin
      mem[wr_ptr] <= pwdata;
    end
  end

  // Control state and output register. The interrupt is registered from the
  // next count, so it changes on the same edge as the count and cannot glitch.
  always_ff @(posedge pclk or negedge clear_b) begin
    if (!clear_b) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      txdata    <= '0;
      ssptxintr <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_next;
      rd_ptr    <= rd_ptr_next;
      count     <= count_next;
      ssptxintr <= (count_next == FULL_CNT);
      if (do_pop) begin
        txdata <= mem[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_tx_fifo.sv
// Directed and randomized bench for tx_fifo. A queue model acts as the
// scoreboard: accepted pushes are queued when driven, and each accepted pop
// dequeues the word that txdata must show after the edge.
module tb_tx_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             pclk;
  logic             clear_b;
  logic             psel;
  logic             pwrite;
  logic             t_en;
  logic [WIDTH-1:0] pwdata;
  logic             ssptxintr;
  logic [WIDTH-1:0] txdata;

  logic [WIDTH-1:0] model_q [$];
  logic [WIDTH-1:0] exp_txdata;
  int               checks;
  int               errors;

  tx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .pclk      (pclk),
    .clear_b   (clear_b),
    .psel      (psel),
    .pwrite    (pwrite),
    .t_en      (t_en),
    .pwdata    (pwdata),
    .ssptxintr (ssptxintr),
    .txdata    (txdata)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, update the scoreboard from the start-of-cycle state,
  // then sample just after the rising edge.
  task automatic cycle(input logic s, input logic w, input logic p, input logic [WIDTH-1:0] d);
    bit do_push;
    bit do_pop;
    @(negedge pclk);
    psel   = s;
    pwrite = w;
    t_en   = p;
    pwdata = d;
    do_push = s && w && (model_q.size() < DEPTH);
    do_pop  = p && (model_q.size() > 0);
    if (do_pop) exp_txdata = model_q.pop_front();
    if (do_push) model_q.push_back(d);
    @(posedge pclk);
    #1;
    check("txdata", 32'(txdata), 32'(exp_txdata));
    check("ssptxintr", 32'(ssptxintr), 32'(model_q.size() == DEPTH));
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    exp_txdata = '0;
    clear_b    = 1'b0;
    psel       = 1'b0;
    pwrite     = 1'b0;
    t_en       = 1'b0;
    pwdata     = '0;

    // Reset state.
    #12;
    check("rst_intr", 32'(ssptxintr), 32'd0);
    check("rst_txdata", 32'(txdata), 32'h00);
    @(negedge pclk);
    clear_b = 1'b1;

    // Fill with 0x00..0x03; full after the fourth edge.
    for (int i = 0; i < DEPTH; i++) cycle(1, 1, 0, 8'(i));
    check("fill_intr", 32'(ssptxintr), 32'd1);

    // Overflow push is dropped.
    cycle(1, 1, 0, 8'h04);
    check("ovf_intr", 32'(ssptxintr), 32'd1);

    // Simultaneous push and pop while full: only the pop happens.
    cycle(1, 1, 1, 8'h04);
    check("full_both_tx", 32'(txdata), 32'h00);
    check("full_both_intr", 32'(ssptxintr), 32'd0);
    // Now mid-occupancy: both happen and 0x04 is accepted.
    cycle(1, 1, 1, 8'h04);
    check("mid_both_tx", 32'(txdata), 32'h01);

    // Drain across the wrap, then one pop on empty.
    cycle(0, 0, 1, 8'hEE);
    check("drain0", 32'(txdata), 32'h02);
    cycle(0, 0, 1, 8'hEE);
    check("drain1", 32'(txdata), 32'h03);
    cycle(0, 0, 1, 8'hEE);
    check("drain2", 32'(txdata), 32'h04);
    cycle(0, 0, 1, 8'hEE);
    check("empty_hold", 32'(txdata), 32'h04);
    check("empty_intr", 32'(ssptxintr), 32'd0);

    // Simultaneous push and pop on empty: push only, no bypass.
    cycle(1, 1, 1, 8'h77);
    check("empty_both_tx", 32'(txdata), 32'h04);
    cycle(0, 0, 1, 8'h00);
    check("empty_both_pop", 32'(txdata), 32'h77);

    // Random traffic to exercise many wraps, full and empty.
    for (int i = 0; i < 60; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 8'($urandom));
    end

    // Reset mid-fill with two words stored and a nonzero txdata.
    for (int i = 0; i < DEPTH + 1 && model_q.size() > 0; i++) cycle(0, 0, 1, 8'h00);
    check("pre_empty", 32'(model_q.size()), 32'd0);
    cycle(1, 1, 0, 8'h5A);
    cycle(1, 1, 0, 8'hA1);
    cycle(1, 1, 1, 8'hA2);
    check("pre_rst_tx", 32'(txdata), 32'h5A);
    @(negedge pclk);
    psel    = 1'b0;
    pwrite  = 1'b0;
    t_en    = 1'b0;
    #1;
    clear_b = 1'b0;
    #1;
    model_q.delete();
    exp_txdata = '0;
    check("midrst_tx", 32'(txdata), 32'h00);
    check("midrst_intr", 32'(ssptxintr), 32'd0);
    @(negedge pclk);
    clear_b = 1'b1;
    cycle(0, 0, 1, 8'h00);
    check("post_rst_pop", 32'(txdata), 32'h00);

    // Operation resumes after reset.
    cycle(1, 1, 0, 8'h3C);
    cycle(0, 0, 1, 8'h00);
    check("resume_tx", 32'(txdata), 32'h3C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL timeout: observed no finish expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/tx_fifo.md
TX_FIFO -- requirements
Module: tx_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, number of FIFO entries (power of two).
REQ-003 Port pclk SHALL be an input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 Port clear_b SHALL be an input, 1 bit, asynchronous active-low reset.
REQ-005 Port psel SHALL be an input, 1 bit, APB peripheral select for this FIFO.
REQ-006 Port pwrite SHALL be an input, 1 bit, APB write strobe; a push requires psel=1 and pwrite=1.
REQ-007 Port t_en SHALL be an input, 1 bit, transmit-logic pop request.
REQ-008 Port pwdata SHALL be an input, WIDTH bits, the word to push.
REQ-009 Port ssptxintr SHALL be an output, 1 bit, transmit interrupt, high while the FIFO is full.
REQ-010 Port txdata SHALL be an output, WIDTH bits, the word most recently popped, registered.

Function
REQ-011 Storage SHALL be a DEPTH x WIDTH circular buffer with registered write pointer, read pointer and occupancy count (0..DEPTH).
REQ-012 Push SHALL occur at a rising edge when psel=1, pwrite=1 and count<DEPTH: mem[wr_ptr]<=pwdata, wr_ptr increments modulo DEPTH.
REQ-013 A push attempted while count==DEPTH SHALL be discarded, with no change to memory, pointers or count.
REQ-014 Pop SHALL occur at a rising edge when t_en=1 and count>0: txdata<=mem[rd_ptr], rd_ptr increments modulo DEPTH.
REQ-015 A pop attempted while count==0 SHALL be ignored; txdata holds its value.
REQ-016 Full/empty evaluation SHALL use the count at the start of the cycle.
REQ-017 Simultaneous push and pop with 0<count<DEPTH SHALL perform both, leaving count unchanged.
REQ-018 Simultaneous push and pop with count==DEPTH SHALL perform only the pop; the push is dropped.
REQ-019 Simultaneous push and pop with count==0 SHALL perform only the push; no bypass to txdata.
REQ-020 txdata SHALL have a latency of one pclk edge from the pop request.
REQ-021 Pointer wrap-around SHALL preserve strict FIFO order across any number of wraps.
REQ-022 ssptxintr SHALL be derived only from the registered count (count==DEPTH), so it is glitch-free, and SHALL update in the same edge as the count change.

Reset
REQ-023 While clear_b=0, pointers, count, txdata (0x00) and ssptxintr (0) SHALL be forced to zero asynchronously.
REQ-024 Memory contents need not be reset.
REQ-025 Reset asserted mid-operation SHALL discard all stored words immediately.
REQ-026 Operation SHALL resume at the first rising edge after clear_b deasserts.

Structure
REQ-027 WIDTH and DEPTH defaults and the derived pointer width (log2 DEPTH) SHALL live in the shared SSP package.
REQ-028 The block SHALL be a single module with no sub-modules.
REQ-029 The transmit-FIFO logic SHALL be kept separable so the receive FIFO can mirror it.

Verification
REQ-030 Reset check: clear_b=0 -> ssptxintr=0, txdata=0x00, FIFO empty.
REQ-031 Fill check: release reset, psel=pwrite=1, push 0x00,0x01,0x02,0x03 on consecutive edges -> ssptxintr=1 after the 4th edge.
REQ-032 Overflow check: push 0x04 while full -> dropped, ssptxintr stays 1.
REQ-033 Full simultaneous check: raise t_en with push still active -> first edge txdata=0x00 with the push dropped; second edge txdata=0x01 and 0x04 accepted.
REQ-034 Drain and wrap check: keep popping -> txdata sequence 0x02,0x03,0x04, then holds 0x04 once empty; ssptxintr=0.
REQ-035 Reset mid-fill check: assert clear_b low with 2 words stored -> count 0; the next pop is ignored and txdata=0x00.
